// File: rtl/falafel_req_arbiter.sv
// Round-robin front end sharing one falafel allocator among NUM_REQ requesters.
// One transaction in flight; the result returns only to the requester that issued it.
module falafel_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_val_i,
  output logic [NUM_REQ-1:0]        req_rdy_o,
  input  logic [NUM_REQ-1:0]        req_is_alloc_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        rsp_val_o,
  input  logic [NUM_REQ-1:0]        rsp_rdy_i,
  output logic                      rsp_is_write_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      is_alloc_o,
  output logic [DATA_W-1:0]         size_to_allocate_o,
  output logic [DATA_W-1:0]         addr_to_free_o,
  output logic                      req_alloc_valid_o,
  input  logic                      alloc_ready_i,
  input  logic                      rsp_result_val_i,
  input  logic                      rsp_result_is_write_i,
  input  logic [DATA_W-1:0]         rsp_result_data_i,
  output logic                      result_ready_o,
  output logic                      busy_o,
  output logic [ID_W-1:0]           grant_id_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DELIVER  = 2'd3
  } state_t;

  state_t              state_r;
  logic [ID_W-1:0]     ptr_r;
  logic [ID_W-1:0]     win_s;
  logic [ID_W-1:0]     next_ptr_s;
  logic                found_s;
  logic                hit_s;
  logic [ID_W:0]       sum_s;
  logic [ID_W:0]       cand_s;
  logic [DATA_W-1:0]   win_data_s;
  logic [NUM_REQ-1:0]  req_rdy_s;

  function automatic logic [NUM_REQ-1:0] grant_mask(input logic [ID_W-1:0] idx);
    grant_mask = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Rotating priority search: first valid requester at or above ptr, wrapping.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    hit_s   = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_s   = {1'b0, ptr_r} + (ID_W+1)'(i);
      cand_s  = (sum_s >= (ID_W+1)'(NUM_REQ)) ? (sum_s - (ID_W+1)'(NUM_REQ)) : sum_s;
      hit_s   = ~found_s & req_val_i[cand_s[ID_W-1:0]];
      win_s   = hit_s ? cand_s[ID_W-1:0] : win_s;
      found_s = found_s | hit_s;
    end
    next_ptr_s = (win_s == ID_W'(NUM_REQ-1)) ? '0 : (win_s + ID_W'(1));
    win_data_s = req_data_i[win_s*DATA_W +: DATA_W];
  end

  // Accept strobe is the only combinational output; held low while reset is asserted.
  always_comb begin
    req_rdy_s = '0;
    if ((state_r == ST_IDLE) && found_s && !rst_i) begin
      req_rdy_s = grant_mask(win_s);
    end else begin
      req_rdy_s = '0;
    end
  end

  assign req_rdy_o = req_rdy_s;

  // Transaction sequencer; every downstream/upstream output is a register updated on transitions.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r            <= ST_IDLE;
      ptr_r              <= '0;
      grant_id_o         <= '0;
      busy_o             <= 1'b0;
      is_alloc_o         <= 1'b0;
      size_to_allocate_o <= '0;
      addr_to_free_o     <= '0;
      req_alloc_valid_o  <= 1'b0;
      result_ready_o     <= 1'b0;
      rsp_val_o          <= '0;
      rsp_is_write_o     <= 1'b0;
      rsp_data_o         <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            state_r            <= ST_ISSUE;
            ptr_r              <= next_ptr_s;
            grant_id_o         <= win_s;
            busy_o             <= 1'b1;
            is_alloc_o         <= req_is_alloc_i[win_s];
            size_to_allocate_o <= req_is_alloc_i[win_s] ? win_data_s : '0;
            addr_to_free_o     <= req_is_alloc_i[win_s] ? '0 : win_data_s;
            req_alloc_valid_o  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (alloc_ready_i) begin
            state_r           <= ST_WAIT_RSP;
            req_alloc_valid_o <= 1'b0;
            result_ready_o    <= 1'b1;
          end
        end
        ST_WAIT_RSP: begin
          if (rsp_result_val_i) begin
            state_r        <= ST_DELIVER;
            result_ready_o <= 1'b0;
            rsp_is_write_o <= rsp_result_is_write_i;
            rsp_data_o     <= rsp_result_data_i;
            rsp_val_o      <= grant_mask(grant_id_o);
          end
        end
        ST_DELIVER: begin
          // Only the owner's ready retires the response.
          if (rsp_rdy_i[grant_id_o]) begin
            state_r   <= ST_IDLE;
            rsp_val_o <= '0;
            busy_o    <= 1'b0;
          end
        end
        default: begin
          state_r           <= ST_IDLE;
          busy_o            <= 1'b0;
          req_alloc_valid_o <= 1'b0;
          result_ready_o    <= 1'b0;
          rsp_val_o         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_falafel_req_arbiter.sv
// Directed bench for falafel_req_arbiter with a transaction-level reference model
// checked every negative clock edge, plus literal expectations from hand analysis.
module tb_falafel_req_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_val_i;
  logic [N-1:0]    req_rdy_o;
  logic [N-1:0]    req_is_alloc_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    rsp_val_o;
  logic [N-1:0]    rsp_rdy_i;
  logic            rsp_is_write_o;
  logic [DW-1:0]   rsp_data_o;
  logic            is_alloc_o;
  logic [DW-1:0]   size_to_allocate_o;
  logic [DW-1:0]   addr_to_free_o;
  logic            req_alloc_valid_o;
  logic            alloc_ready_i;
  logic            rsp_result_val_i;
  logic            rsp_result_is_write_i;
  logic [DW-1:0]   rsp_result_data_i;
  logic            result_ready_o;
  logic            busy_o;
  logic [IW-1:0]   grant_id_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  falafel_req_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_val_i(req_val_i), .req_rdy_o(req_rdy_o),
    .req_is_alloc_i(req_is_alloc_i), .req_data_i(req_data_i),
    .rsp_val_o(rsp_val_o), .rsp_rdy_i(rsp_rdy_i),
    .rsp_is_write_o(rsp_is_write_o), .rsp_data_o(rsp_data_o),
    .is_alloc_o(is_alloc_o), .size_to_allocate_o(size_to_allocate_o),
    .addr_to_free_o(addr_to_free_o), .req_alloc_valid_o(req_alloc_valid_o),
    .alloc_ready_i(alloc_ready_i), .rsp_result_val_i(rsp_result_val_i),
    .rsp_result_is_write_i(rsp_result_is_write_i), .rsp_result_data_i(rsp_result_data_i),
    .result_ready_o(result_ready_o), .busy_o(busy_o), .grant_id_o(grant_id_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: stage 0 free, 1 offering to allocator, 2 awaiting result, 3 handing back.
  int            m_stage = 0;
  int            m_owner = 0;
  int            m_ptr   = 0;
  logic          m_is_alloc = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic          m_rw    = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  int            m_win;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    onehot = '0;
    if (i >= 0) onehot[i] = 1'b1;
  endfunction

  always_comb m_win = pick(req_val_i, m_ptr);

  // Model advance on the same edge the design uses.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stage <= 0; m_owner <= 0; m_ptr <= 0;
      m_is_alloc <= 1'b0; m_data <= '0; m_rw <= 1'b0; m_rdata <= '0;
    end else begin
      case (m_stage)
        0: if (m_win >= 0) begin
             m_owner    <= m_win;
             m_ptr      <= (m_win + 1) % N;
             m_is_alloc <= req_is_alloc_i[m_win];
             m_data     <= req_data_i[m_win*DW +: DW];
             m_stage    <= 1;
           end
        1: if (alloc_ready_i) m_stage <= 2;
        2: if (rsp_result_val_i) begin
             m_rw    <= rsp_result_is_write_i;
             m_rdata <= rsp_result_data_i;
             m_stage <= 3;
           end
        3: if (rsp_rdy_i[m_owner]) m_stage <= 0;
        default: m_stage <= 0;
      endcase
    end
  end

  // Compare the design against the model away from the active edge.
  always @(negedge clk) begin
    chk("req_rdy", 64'(req_rdy_o), 64'((m_stage == 0 && !rst) ? onehot(m_win) : 4'b0000));
    chk("alloc_valid", 64'(req_alloc_valid_o), 64'(m_stage == 1));
    chk("result_ready", 64'(result_ready_o), 64'(m_stage == 2));
    chk("busy", 64'(busy_o), 64'(m_stage != 0));
    chk("rsp_val", 64'(rsp_val_o), 64'((m_stage == 3) ? onehot(m_owner) : 4'b0000));
    if (m_stage != 0) chk("grant_id", 64'(grant_id_o), 64'(m_owner));
    if (m_stage == 1) begin
      chk("is_alloc", 64'(is_alloc_o), 64'(m_is_alloc));
      chk("size", size_to_allocate_o, m_is_alloc ? m_data : 64'h0);
      chk("addr", addr_to_free_o, m_is_alloc ? 64'h0 : m_data);
    end
    if (m_stage == 3) begin
      chk("rsp_is_write", 64'(rsp_is_write_o), 64'(m_rw));
      chk("rsp_data", rsp_data_o, m_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic alloc, input logic [DW-1:0] d);
    req_is_alloc_i[k]       = alloc;
    req_data_i[k*DW +: DW]  = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_rdy"}, 64'(req_rdy_o), 64'h0);
    chk({tag, "_rsp_val"}, 64'(rsp_val_o), 64'h0);
    chk({tag, "_alloc_valid"}, 64'(req_alloc_valid_o), 64'h0);
    chk({tag, "_result_ready"}, 64'(result_ready_o), 64'h0);
    chk({tag, "_busy"}, 64'(busy_o), 64'h0);
    chk({tag, "_grant_id"}, 64'(grant_id_o), 64'h0);
    chk({tag, "_is_alloc"}, 64'(is_alloc_o), 64'h0);
    chk({tag, "_size"}, size_to_allocate_o, 64'h0);
    chk({tag, "_addr"}, addr_to_free_o, 64'h0);
    chk({tag, "_rsp_is_write"}, 64'(rsp_is_write_o), 64'h0);
    chk({tag, "_rsp_data"}, rsp_data_o, 64'h0);
  endtask

  int rr_log[$];
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    req_val_i = '0; req_is_alloc_i = '0; req_data_i = '0; rsp_rdy_i = '0;
    alloc_ready_i = 1'b0; rsp_result_val_i = 1'b0; rsp_result_is_write_i = 1'b0;
    rsp_result_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Round robin from reset: all four requesters always valid.
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 64'h100 + 64'(k));
    req_val_i = 4'hF; alloc_ready_i = 1'b1; rsp_result_val_i = 1'b1; rsp_rdy_i = 4'hF;
    for (int c = 0; c < 19; c++) begin
      rsp_result_data_i = 64'hA000 + 64'(c);
      tick();
      if (req_alloc_valid_o) rr_log.push_back(int'(grant_id_o));
    end
    req_val_i = '0;
    tick();
    rsp_result_val_i = 1'b0; rsp_rdy_i = '0; alloc_ready_i = 1'b0;
    chk("rr_count", 64'(rr_log.size()), 64'd5);
    for (int k = 0; k < 5 && k < rr_log.size(); k++) chk("rr_order", 64'(rr_log[k]), 64'(rr_exp[k]));

    // Single alloc from requester 2 at minimum latency.
    set_req(2, 1'b1, 64'h40); req_val_i = 4'b0100; alloc_ready_i = 1'b1;
    #1 chk("single_rdy_T", 64'(req_rdy_o), 64'h4);
    tick();
    req_val_i = '0;
    chk("single_valid_T1", 64'(req_alloc_valid_o), 64'h1);
    chk("single_size_T1", size_to_allocate_o, 64'h40);
    chk("single_addr_T1", addr_to_free_o, 64'h0);
    chk("single_gid_T1", 64'(grant_id_o), 64'h2);
    tick();
    chk("single_rr_T2", 64'(result_ready_o), 64'h1);
    rsp_result_val_i = 1'b1; rsp_result_data_i = 64'h1000; rsp_result_is_write_i = 1'b0;
    rsp_rdy_i = 4'b0100;
    tick();
    rsp_result_val_i = 1'b0;
    chk("single_rspval_T3", 64'(rsp_val_o), 64'h4);
    chk("single_rspdata_T3", rsp_data_o, 64'h1000);
    tick();
    chk("single_idle_T4", 64'(busy_o), 64'h0);
    rsp_rdy_i = '0; alloc_ready_i = 1'b0;

    // Free path from requester 1.
    set_req(1, 1'b0, 64'h2000); req_val_i = 4'b0010; alloc_ready_i = 1'b1;
    #1 chk("free_rdy", 64'(req_rdy_o), 64'h2);
    tick();
    req_val_i = '0;
    chk("free_is_alloc", 64'(is_alloc_o), 64'h0);
    chk("free_addr", addr_to_free_o, 64'h2000);
    chk("free_size", size_to_allocate_o, 64'h0);
    tick();
    rsp_result_val_i = 1'b1; rsp_result_is_write_i = 1'b1; rsp_result_data_i = 64'h0;
    rsp_rdy_i = 4'b0010;
    tick();
    rsp_result_val_i = 1'b0; rsp_result_is_write_i = 1'b0;
    chk("free_is_write", 64'(rsp_is_write_o), 64'h1);
    chk("free_rsp_val", 64'(rsp_val_o), 64'h2);
    tick();
    rsp_rdy_i = '0; alloc_ready_i = 1'b0;

    // Backpressure and spurious inputs on requester 3.
    set_req(3, 1'b1, 64'h77); req_val_i = 4'b1000;
    #1 chk("bp_rdy", 64'(req_rdy_o), 64'h8);
    tick();
    req_val_i = '0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", 64'(req_alloc_valid_o), 64'h1);
      chk("bp_hold_size", size_to_allocate_o, 64'h77);
      chk("bp_no_result_ready", 64'(result_ready_o), 64'h0);
      rsp_result_val_i = 1'b1; rsp_result_data_i = 64'hDEAD;
      tick();
    end
    rsp_result_val_i = 1'b0; alloc_ready_i = 1'b1;
    tick();
    alloc_ready_i = 1'b0;
    set_req(0, 1'b1, 64'h11); req_val_i = 4'b0001;
    #1 chk("wait_no_accept", 64'(req_rdy_o), 64'h0);
    rsp_result_val_i = 1'b1; rsp_result_data_i = 64'hBEEF;
    tick();
    rsp_result_val_i = 1'b0; req_val_i = '0;
    for (int c = 0; c < 5; c++) begin
      rsp_rdy_i = 4'b0111;
      #1;
      chk("bp_hold_rsp_val", 64'(rsp_val_o), 64'h8);
      chk("bp_hold_rsp_data", rsp_data_o, 64'hBEEF);
      tick();
    end
    rsp_rdy_i = 4'b1000;
    tick();
    chk("bp_done", 64'(busy_o), 64'h0);
    rsp_rdy_i = '0;

    // Reset during WAIT_RSP, then requester 0 must win first.
    set_req(2, 1'b1, 64'h99); req_val_i = 4'b0100; alloc_ready_i = 1'b1;
    tick();
    req_val_i = '0;
    tick();
    chk("mid_wait", 64'(result_ready_o), 64'h1);
    req_val_i = 4'hF;
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    tick();
    rst = 1'b0;
    #1 chk("post_rst_winner", 64'(req_rdy_o), 64'h1);
    tick();
    req_val_i = '0;
    chk("post_rst_gid", 64'(grant_id_o), 64'h0);
    tick();
    rsp_result_val_i = 1'b1; rsp_rdy_i = 4'b0001;
    tick();
    rsp_result_val_i = 1'b0;
    tick();
    chk("post_rst_idle", 64'(busy_o), 64'h0);
    rsp_rdy_i = '0; alloc_ready_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
